// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: accepts one op, runs it, holds a registered response.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_valid_i,
    input  logic            req1_valid_i,
    output logic            req0_ready_o,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req0_a_i,
    input  logic [XLEN-1:0] req0_b_i,
    input  logic [XLEN-1:0] req1_a_i,
    input  logic [XLEN-1:0] req1_b_i,
    input  logic [3:0]      req0_op_i,
    input  logic [3:0]      req1_op_i,
    output logic [XLEN-1:0] alu_in1_o,
    output logic [XLEN-1:0] alu_in2_o,
    output logic [3:0]      alu_op_o,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            alu_zero_i,
    input  logic            alu_neg_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_zero_o,
    output logic            rsp_neg_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] OpMult     = 4'd12;
    localparam logic [3:0] OpDiv      = 4'd13;
    localparam logic [3:0] MulDivLoad = 4'(MULDIV_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              id_q, id_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d, rsp_neg_q, rsp_neg_d, rsp_id_q, rsp_id_d;
    logic              grant0, grant1, accept;
    logic [3:0]        sel_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
        end else begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i;
        end
    end

    // Point at the requester that lost this acceptance.
    assign ptr_d = accept ? grant0 : ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    assign grant0 = req0_valid_i;
    assign grant1 = req1_valid_i & ~req0_valid_i;
`endif

    // Ready is masked while reset is held so nothing looks accepted during reset.
    assign accept       = (state_q == StIdle) && !rst_i && (grant0 || grant1);
    assign req0_ready_o = (state_q == StIdle) && !rst_i && grant0;
    assign req1_ready_o = (state_q == StIdle) && !rst_i && grant1;
    assign sel_op       = grant0 ? req0_op_i : req1_op_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_neg_d  = rsp_neg_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = grant0 ? req0_a_i : req1_a_i;
                    b_d     = grant0 ? req0_b_i : req1_b_i;
                    op_d    = sel_op;
                    id_d    = grant1;
                    cnt_d   = (sel_op == OpMult || sel_op == OpDiv) ? MulDivLoad : 4'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d = alu_out_i;
                    rsp_zero_d = alu_zero_i;
                    rsp_neg_d  = alu_neg_i;
                    rsp_id_d   = id_q;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 4'd0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_neg_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_neg_q  <= rsp_neg_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign alu_in1_o   = a_q;
    assign alu_in2_o   = b_q;
    assign alu_op_o    = (state_q == StIdle) ? 4'd0 : op_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_neg_o   = rsp_neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk, rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_op, req1_op;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
    logic [3:0]      alu_op;
    logic            alu_zero, alu_neg;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg;
    logic [XLEN-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.XLEN(XLEN), .MULDIV_LAT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
        .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .req0_op_i(req0_op), .req1_op_i(req1_op),
        .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op),
        .alu_out_i(alu_out), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'd8:    alu_out = alu_in1 + alu_in2;
            4'd10:   alu_out = alu_in1 - alu_in2;
            4'd12:   alu_out = alu_in1 * alu_in2;
            4'd13:   alu_out = (alu_in2 != 0) ? alu_in1 / alu_in2 : '1;
            default: alu_out = alu_in1;
        endcase
        alu_zero = (alu_out == 0);
        alu_neg  = alu_out[XLEN-1];
    end

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_op = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 0) begin errors++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        checks++; if ({rsp_id, rsp_zero, rsp_neg} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {rsp_id, rsp_zero, rsp_neg}); end
        checks++; if (alu_op !== 4'd0 || alu_in1 !== 0 || alu_in2 !== 0) begin errors++; $display("FAIL rst_alu got op=%h in1=%h in2=%h exp all 0", alu_op, alu_in1, alu_in2); end
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL first_idle_ready got=%b exp=1", req0_ready); end
        req0_valid = 1'b0;
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_op = 4'd8;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready); end
        checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL idle_nop got=%h exp=0", alu_op); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid got=%b exp=0", rsp_valid); end
        checks++; if (alu_op !== 4'd8 || alu_in1 !== 5 || alu_in2 !== 7) begin errors++; $display("FAIL add_alu_drive got op=%h in1=%0d in2=%0d exp 8/5/7", alu_op, alu_in1, alu_in2); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 12 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL add_rsp got data=%0d id=%b zero=%b exp 12/0/0", rsp_data, rsp_id, rsp_zero); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_mult();
        req1_valid = 1'b1; req1_a = 6; req1_b = 7; req1_op = 4'd12;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL mult_ready got=%b%b exp=01", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_op = 4'd8;
        #1;
        checks++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mult_exec0 got ready=%b valid=%b exp 0/0", req0_ready, rsp_valid); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mult_exec%0d got ready=%b valid=%b exp 0/0", k, req0_ready, rsp_valid); end
        end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mult_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 42 || rsp_id !== 1'b1) begin errors++; $display("FAIL mult_rsp got data=%0d id=%b exp 42/1", rsp_data, rsp_id); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL mult_resp_ready got=%b exp=0", req0_ready); end
        req0_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mult_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic ids [4];
        logic exp_id;
        int   n = 0;
        req0_valid = 1'b1; req0_a = 3; req0_b = 5; req0_op = 4'd10;
        req1_valid = 1'b1; req1_a = 3; req1_b = 5; req1_op = 4'd10;
        rsp_ready  = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                ids[n] = rsp_id;
                if (n == 0) begin
                    checks++; if (rsp_data !== 32'hFFFF_FFFE || rsp_neg !== 1'b1) begin errors++; $display("FAIL sub_rsp got data=%h neg=%b exp fffffffe/1", rsp_data, rsp_neg); end
                end
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL contention_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_id = (i % 2 == 1);
`else
            exp_id = 1'b0;
`endif
            checks++; if (ids[i] !== exp_id) begin errors++; $display("FAIL contention_id%0d got=%b exp=%b", i, ids[i], exp_id); end
        end
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL contention_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_hold();
        req0_valid = 1'b1; req0_a = 100; req0_b = 23; req0_op = 4'd8;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 9; req1_b = 9; req1_op = 4'd8;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d got=%b exp=1", i, rsp_valid); end
            checks++; if (rsp_data !== 123 || rsp_id !== 1'b0) begin errors++; $display("FAIL hold_data%0d got data=%0d id=%b exp 123/0", i, rsp_data, rsp_id); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready1=%b exp 0/1", rsp_valid, req1_ready); end
        req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        req1_valid = 1'b1; req1_a = 84; req1_b = 2; req1_op = 4'd13;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = 4'd8;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 0 || rsp_id !== 1'b0) begin errors++; $display("FAIL abort_rsp got valid=%b data=%h id=%b exp 0/0/0", rsp_valid, rsp_data, rsp_id); end
        checks++; if (alu_op !== 4'd0 || alu_in1 !== 0 || alu_in2 !== 0) begin errors++; $display("FAIL abort_alu got op=%h in1=%h in2=%h exp all 0", alu_op, alu_in1, alu_in2); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", req0_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL abort_reaccept got=%b exp=1", req0_ready); end
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(posedge clk); #1;
            req0_valid = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_new_rsp got=%b exp=1", seen); end
        checks++; if (rsp_data !== 3 || rsp_id !== 1'b0) begin errors++; $display("FAIL abort_new_data got data=%0d id=%b exp 3/0", rsp_data, rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_drain got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 4'd0; req1_op = 4'd0;
        test_reset();
        test_add();
        test_mult();
        test_contention();
        test_hold();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
